// File: rtl/alu_result_buffer_pkg.sv
// Shared constants and entry layout for the likeALU result-capture path.
package alu_result_buffer_pkg;

  // Widths shared with likeALU and its bench.
  localparam int unsigned ALU_W     = 5;
  localparam int unsigned ALU_SEL_W = 2;

  // Packed entry layout {sel, zero, data}, LSB first: data, then zero, then sel.
  localparam int unsigned ENTRY_DATA_LSB = 0;
  localparam int unsigned ENTRY_ZERO_BIT = ALU_W;
  localparam int unsigned ENTRY_SEL_LSB  = ALU_W + 1;
  localparam int unsigned ENTRY_W        = ALU_SEL_W + 1 + ALU_W;

  typedef struct packed {
    logic [ALU_SEL_W-1:0] sel;
    logic                 zero;
    logic [ALU_W-1:0]     data;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO capturing likeALU results tagged with their select and a zero flag.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_W,
  parameter int unsigned SEL_W  = ALU_SEL_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [SEL_W-1:0]  rd_sel,
  output logic              rd_zero,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned ENT_W    = SEL_W + 1 + DATA_W;
  // Same {sel, zero, data} ordering as the package layout, scaled to the parameters.
  localparam int unsigned ZERO_BIT = DATA_W;
  localparam int unsigned SEL_LSB  = DATA_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop;
  logic [ENT_W-1:0] head;

  // Handshake decode; a full FIFO still accepts a push when the head leaves this cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
    pop   = !empty && rd_ready;
    push  = wr_en && (!full || pop);
    drop  = wr_en && full && !pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag (set beats clear).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state with asynchronous reset; storage itself is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; zero flag is captured at push time so consumers need not decode data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {wr_sel, (wr_data == '0), wr_data};
    end
  end

  // Show-ahead read of the head entry, gated to zero while nothing is held.
  always_comb begin
    head     = mem_q[rptr_q];
    rd_valid = !empty;
    rd_data  = rd_valid ? head[DATA_W-1:0] : '0;
    rd_zero  = rd_valid ? head[ZERO_BIT] : 1'b0;
    rd_sel   = rd_valid ? head[SEL_LSB +: SEL_W] : '0;
    count    = count_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [ALU_W-1:0] wr_data;
  logic [ALU_SEL_W-1:0] wr_sel;
  logic             rd_ready;
  logic             rd_valid;
  logic [ALU_W-1:0] rd_data;
  logic [ALU_SEL_W-1:0] rd_sel;
  logic             rd_zero;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             ovf_clr;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: an ordered list of held results plus the sticky flag.
  logic [ALU_W-1:0]     mq_data[$];
  logic [ALU_SEL_W-1:0] mq_sel[$];
  bit                   m_ovf;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_sel   (rd_sel),
    .rd_zero  (rd_zero),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Advance one clock: model consumes the inputs present before the edge; returns at edge+1.
  task automatic tick();
    bit pop, push, drop;
    pop  = (mq_data.size() != 0) && rd_ready;
    push = wr_en && ((mq_data.size() < DEPTH) || pop);
    drop = wr_en && (mq_data.size() == DEPTH) && !pop;
    @(posedge clk);
    if (pop) begin
      void'(mq_data.pop_front());
      void'(mq_sel.pop_front());
    end
    if (push) begin
      mq_data.push_back(wr_data);
      mq_sel.push_back(wr_sel);
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_sel   = '0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic push_one(input logic [ALU_W-1:0] d, input logic [ALU_SEL_W-1:0] s);
    wr_en = 1'b1; wr_data = d; wr_sel = s; rd_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({empty, full, rd_valid, count, overflow} !== {1'b1, 1'b0, 1'b0, CW'(0), 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_flags: got empty=%b full=%b valid=%b count=%0d ovf=%b", empty, full,
               rd_valid, count, overflow);
    end
    tests_run++;
    if ({rd_data, rd_sel, rd_zero} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rd: got data=%b sel=%b zero=%b, want all 0", rd_data, rd_sel, rd_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_midstream_reset();
    push_one(5'b00111, 2'b01);
    push_one(5'b01100, 2'b10);
    tests_run++;
    if (count !== CW'(2)) begin
      tests_failed++;
      $display("FAIL mid_reset_pre_count: got %0d want 2", count);
    end
    #2 rst_n = 1'b0;
    #1;
    mq_data.delete(); mq_sel.delete(); m_ovf = 1'b0;
    tests_run++;
    if ({empty, count, rd_valid, rd_data} !== {1'b1, CW'(0), 1'b0, 5'b00000}) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got empty=%b count=%0d valid=%b data=%b", empty, count,
               rd_valid, rd_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_in_order();
    logic [ALU_W-1:0]     exp_d [3] = '{5'b00001, 5'b00000, 5'b11111};
    logic [ALU_SEL_W-1:0] exp_s [3] = '{2'b01, 2'b10, 2'b11};
    logic                 exp_z [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) push_one(exp_d[i], exp_s[i]);
    tests_run++;
    if (count !== CW'(3)) begin
      tests_failed++;
      $display("FAIL in_order_count: got %0d want 3", count);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({rd_valid, rd_data, rd_sel, rd_zero} !== {1'b1, exp_d[i], exp_s[i], exp_z[i]}) begin
        tests_failed++;
        $display("FAIL in_order_pop%0d: got v=%b d=%b s=%b z=%b want d=%b s=%b z=%b", i,
                 rd_valid, rd_data, rd_sel, rd_zero, exp_d[i], exp_s[i], exp_z[i]);
      end
      tick();
    end
    idle_inputs();
    tests_run++;
    if (empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL in_order_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 5; i++) begin
      push_one(5'(16 + i), 2'(i));
      tests_run++;
      if (full !== (i >= 3)) begin
        tests_failed++;
        $display("FAIL fill_full%0d: got %b want %b", i, full, (i >= 3));
      end
    end
    tests_run++;
    if ({overflow, count, rd_data} !== {1'b1, CW'(4), 5'b10000}) begin
      tests_failed++;
      $display("FAIL fill_drop: got ovf=%b count=%0d head=%b want 1/4/10000", overflow, count,
               rd_data);
    end
    ovf_clr = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if ({overflow, count} !== {1'b0, CW'(4)}) begin
      tests_failed++;
      $display("FAIL ovf_clr: got ovf=%b count=%0d want 0/4", overflow, count);
    end
  endtask

  // Starts from the full FIFO left by test_fill_overflow (10000..10011).
  task automatic test_full_push_pop();
    logic [ALU_W-1:0] exp_d [4] = '{5'b10001, 5'b10010, 5'b10011, 5'b11000};
    wr_en = 1'b1; wr_data = 5'b11000; wr_sel = 2'b10; rd_ready = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if ({count, overflow, full} !== {CW'(4), 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL full_pp: got count=%0d ovf=%b full=%b want 4/0/1", count, overflow, full);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL full_pp_drain%0d: got %b want %b", i, rd_data, exp_d[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int max_cnt = 0;
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      push_one(5'(i), 2'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tests_run++;
      if ({rd_valid, rd_data, rd_sel, rd_zero} !== {1'b1, 5'(i), 2'(i), (i == 0)}) begin
        tests_failed++;
        $display("FAIL wrap_pop%0d: got v=%b d=%b s=%b z=%b", i, rd_valid, rd_data, rd_sel,
                 rd_zero);
      end
      rd_ready = 1'b1;
      tick();
      idle_inputs();
      if (count !== CW'(0)) bad++;
    end
    tests_run++;
    if (max_cnt != 1 || bad != 0) begin
      tests_failed++;
      $display("FAIL wrap_count: got max=%0d nonzero_after_pop=%0d want 1/0", max_cnt, bad);
    end
  endtask

  // Empty with push and ready both high must not bypass; then sustained push+pop.
  task automatic test_back_to_back();
    wr_en = 1'b1; rd_ready = 1'b1; wr_sel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      wr_data = 5'(7 + 3 * i);
      tick();
      tests_run++;
      if ({count, rd_valid, rd_data} !== {CW'(1), 1'b1, 5'(7 + 3 * i)}) begin
        tests_failed++;
        $display("FAIL b2b%0d: got count=%0d v=%b d=%b want 1/1/%b", i, count, rd_valid,
                 rd_data, 5'(7 + 3 * i));
      end
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_ovf_priority();
    for (int i = 0; i < 4; i++) push_one(5'(i + 1), 2'b00);
    wr_en = 1'b1; wr_data = 5'b01010; ovf_clr = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_lone_clr: got %b want 0", overflow);
    end
    drain();
  endtask

  task automatic test_random();
    logic [ALU_W-1:0]     ed;
    logic [ALU_SEL_W-1:0] es;
    for (int i = 0; i < 300; i++) begin
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_data  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      wr_sel   = 2'($urandom);
      rd_ready = ($urandom_range(0, 2) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
      ed = (mq_data.size() != 0) ? mq_data[0] : '0;
      es = (mq_sel.size() != 0) ? mq_sel[0] : '0;
      tests_run++;
      if ({count, full, empty, overflow} !==
          {CW'(mq_data.size()), mq_data.size() == DEPTH, mq_data.size() == 0, m_ovf}) begin
        tests_failed++;
        $display("FAIL rand_state%0d: got count=%0d full=%b empty=%b ovf=%b want %0d/%b", i,
                 count, full, empty, overflow, mq_data.size(), m_ovf);
      end
      tests_run++;
      if ({rd_valid, rd_data, rd_sel, rd_zero} !==
          {mq_data.size() != 0, ed, es, (mq_data.size() != 0) && (ed == 0)}) begin
        tests_failed++;
        $display("FAIL rand_head%0d: got v=%b d=%b s=%b z=%b want d=%b s=%b", i, rd_valid,
                 rd_data, rd_sel, rd_zero, ed, es);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    m_ovf = 1'b0;
    #2;
    test_reset();
    test_midstream_reset();
    test_in_order();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_back_to_back();
    test_ovf_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
